// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file with pending-write scoreboard.
// Used by regfile_sb and sb_counter. The optional bypass is selected with REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;
    localparam int DEF_AW    = $clog2(DEF_NREGS);

    typedef logic [DEF_AW-1:0]   reg_addr_t;
    typedef logic [DEF_XLEN-1:0] xword_t;

endpackage

// File: rtl/sb_counter.sv
// One per-register pending-write counter: up on accepted reservation, down on writeback.
// The drains output exists only when REGFILE_BYPASS_EN is defined.
module sb_counter
    import regfile_pkg::*;
#(
    parameter  int MAX_PENDING = 3,
    localparam int CW          = $clog2(MAX_PENDING + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic nonzero,
    output logic underflow
`ifdef REGFILE_BYPASS_EN
    ,
    output logic drains
`endif
);

    logic [CW-1:0] cnt;
    logic          inc_ok;
    logic          dec_ok;

    assign full      = (cnt == CW'(MAX_PENDING));
    assign nonzero   = (cnt != '0);
    assign underflow = dec && !nonzero;

    // A writeback in the same cycle frees the slot a full counter would otherwise refuse.
    assign inc_ok = inc && (!full || dec);
    assign dec_ok = dec && nonzero;

`ifdef REGFILE_BYPASS_EN
    assign drains = dec && !inc_ok && (cnt == CW'(1));
`endif

    // NOTE: clocked state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (inc_ok && !dec_ok) begin
            cnt <= cnt + CW'(1);
        end else if (dec_ok && !inc_ok) begin
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with NRD combinational read ports, one write port and a per-register scoreboard.
// Defining REGFILE_BYPASS_EN forwards same-cycle writeback data and busy clearing to the read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int XLEN        = DEF_XLEN,
    parameter  int NREGS       = DEF_NREGS,
    parameter  int NRD         = 2,
    parameter  int MAX_PENDING = 3,
    localparam int AW          = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NRD-1:0][AW-1:0]   read_reg,
    output logic [NRD-1:0][XLEN-1:0] read_data,
    output logic [NRD-1:0]           read_busy,
    input  logic [AW-1:0]            write_reg,
    input  logic [XLEN-1:0]          write_data,
    input  logic                     regwrite,
    input  logic                     reserve_valid,
    input  logic [AW-1:0]            reserve_reg,
    output logic                     reserve_ready,
    output logic                     sb_error
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] full;
    logic [NREGS-1:0] nonzero;
    logic [NREGS-1:0] underflow;
`ifdef REGFILE_BYPASS_EN
    logic [NREGS-1:0] drains;
    assign drains[0] = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the whole array is reset, not just x0, because every address must read 0 after reset.
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else if (regwrite && write_reg != '0) begin
            regs[write_reg] <= write_data;
        end
    end

    // x0 has no counter: never busy, never full, never underflows.
    assign full[0]      = 1'b0;
    assign nonzero[0]   = 1'b0;
    assign underflow[0] = 1'b0;

    for (genvar r = 1; r < NREGS; r++) begin : g_cnt
        logic inc;
        logic dec;

        assign inc = reserve_valid && reserve_ready && (reserve_reg == AW'(r));
        assign dec = regwrite && (write_reg == AW'(r));

        sb_counter #(
            .MAX_PENDING (MAX_PENDING)
        ) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .inc       (inc),
            .dec       (dec),
            .full      (full[r]),
            .nonzero   (nonzero[r]),
            .underflow (underflow[r])
`ifdef REGFILE_BYPASS_EN
            ,
            .drains    (drains[r])
`endif
        );
    end

    assign reserve_ready = (reserve_reg == '0) || !full[reserve_reg]
                         || (regwrite && write_reg == reserve_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_error <= 1'b0;
        end else if (|underflow) begin
            sb_error <= 1'b1;
        end
    end

    // NOTE: every output is given a value before any conditional override, so no latch is inferred.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            read_data[i] = regs[read_reg[i]];
            read_busy[i] = nonzero[read_reg[i]];
`ifdef REGFILE_BYPASS_EN
            if (regwrite && write_reg != '0 && write_reg == read_reg[i]) begin
                read_data[i] = write_data;
                if (drains[read_reg[i]]) begin
                    read_busy[i] = 1'b0;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed vector table plus hand-written reset/bypass sequences.
// Expectations for the x9 writeback sequence depend on REGFILE_BYPASS_EN.
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int NRD = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NRD-1:0][4:0]   read_reg;
    logic [NRD-1:0][31:0]  read_data;
    logic [NRD-1:0]        read_busy;
    reg_addr_t             write_reg;
    xword_t                write_data;
    logic                  regwrite;
    logic                  reserve_valid;
    reg_addr_t             reserve_reg;
    logic                  reserve_ready;
    logic                  sb_error;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_sb #(
        .XLEN        (32),
        .NREGS       (32),
        .NRD         (NRD),
        .MAX_PENDING (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .read_reg      (read_reg),
        .read_data     (read_data),
        .read_busy     (read_busy),
        .write_reg     (write_reg),
        .write_data    (write_data),
        .regwrite      (regwrite),
        .reserve_valid (reserve_valid),
        .reserve_reg   (reserve_reg),
        .reserve_ready (reserve_ready),
        .sb_error      (sb_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs0, rs1;
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        rv;
        logic [4:0]  rr;
        logic [31:0] e_d0, e_d1;
        logic [1:0]  e_busy;
        logic        e_rdy, e_err;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(logic [4:0] rs0, logic [4:0] rs1, logic we, logic [4:0] wr,
                                logic [31:0] wd, logic rv, logic [4:0] rr, logic [31:0] e_d0,
                                logic [31:0] e_d1, logic [1:0] e_busy, logic e_rdy, logic e_err);
        vec_t v;
        v.rs0 = rs0; v.rs1 = rs1; v.we = we; v.wr = wr; v.wd = wd; v.rv = rv; v.rr = rr;
        v.e_d0 = e_d0; v.e_d1 = e_d1; v.e_busy = e_busy; v.e_rdy = e_rdy; v.e_err = e_err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge and let combinational outputs settle.
    task automatic drive(input logic rst, input logic [4:0] rs0, input logic [4:0] rs1,
                         input logic we, input logic [4:0] wr, input logic [31:0] wd,
                         input logic rv, input logic [4:0] rr);
        @(negedge clk);
        reset         = rst;
        read_reg[0]   = rs0;
        read_reg[1]   = rs1;
        regwrite      = we;
        write_reg     = wr;
        write_data    = wd;
        reserve_valid = rv;
        reserve_reg   = rr;
        #1;
    endtask

    initial begin
        reset = 1'b1; read_reg = '0; regwrite = 1'b0; write_reg = '0; write_data = '0;
        reserve_valid = 1'b0; reserve_reg = '0;

        // Columns: rs0 rs1 we wr wd rv rr | d0 d1 busy{p1,p0} ready err
        tbl[0]  = mk(5, 0, 0, 0, 32'h0,        1, 5,  32'h0,        32'h0,        2'b00, 1, 0);
        tbl[1]  = mk(4, 0, 1, 5, 32'hDEADBEEF, 0, 5,  32'h0,        32'h0,        2'b00, 1, 0);
        tbl[2]  = mk(5, 0, 1, 0, 32'h1234,     1, 0,  32'hDEADBEEF, 32'h0,        2'b00, 1, 0);
        tbl[3]  = mk(0, 5, 0, 0, 32'h0,        0, 0,  32'h0,        32'hDEADBEEF, 2'b00, 1, 0);
        tbl[4]  = mk(7, 0, 0, 0, 32'h0,        1, 7,  32'h0,        32'h0,        2'b00, 1, 0);
        tbl[5]  = mk(7, 0, 0, 0, 32'h0,        1, 7,  32'h0,        32'h0,        2'b01, 1, 0);
        tbl[6]  = mk(7, 7, 0, 0, 32'h0,        1, 7,  32'h0,        32'h0,        2'b11, 1, 0);
        tbl[7]  = mk(7, 7, 0, 0, 32'h0,        1, 7,  32'h0,        32'h0,        2'b11, 0, 0);
        tbl[8]  = mk(7, 0, 0, 0, 32'h0,        0, 7,  32'h0,        32'h0,        2'b01, 0, 0);
        tbl[9]  = mk(6, 0, 1, 7, 32'h77,       1, 7,  32'h0,        32'h0,        2'b00, 1, 0);
        tbl[10] = mk(7, 0, 0, 0, 32'h0,        0, 7,  32'h77,       32'h0,        2'b01, 0, 0);
        tbl[11] = mk(0, 0, 1, 7, 32'h78,       0, 7,  32'h0,        32'h0,        2'b00, 1, 0);
        tbl[12] = mk(7, 0, 0, 0, 32'h0,        0, 7,  32'h78,       32'h0,        2'b01, 1, 0);
        tbl[13] = mk(2, 0, 1, 3, 32'h33,       0, 3,  32'h0,        32'h0,        2'b00, 1, 0);
        tbl[14] = mk(3, 0, 0, 0, 32'h0,        0, 3,  32'h33,       32'h0,        2'b00, 1, 1);
        tbl[15] = mk(0, 0, 0, 0, 32'h0,        0, 0,  32'h0,        32'h0,        2'b00, 1, 1);

        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);

        // Post-reset sweep of every address on both ports.
        for (int a = 0; a < 32; a++) begin
            drive(0, 5'(a), 5'(31 - a), 0, 0, 0, 0, 5'(a));
            check($sformatf("rst d0 x%0d", a), read_data[0], 32'h0);
            check($sformatf("rst d1 x%0d", 31 - a), read_data[1], 32'h0);
            check($sformatf("rst busy x%0d", a), 32'(read_busy), 32'h0);
            check($sformatf("rst ready x%0d", a), 32'(reserve_ready), 32'h1);
        end
        check("rst sb_error", 32'(sb_error), 32'h0);

        for (int i = 0; i < 16; i++) begin
            drive(0, tbl[i].rs0, tbl[i].rs1, tbl[i].we, tbl[i].wr, tbl[i].wd, tbl[i].rv, tbl[i].rr);
            check($sformatf("v%0d d0", i), read_data[0], tbl[i].e_d0);
            check($sformatf("v%0d d1", i), read_data[1], tbl[i].e_d1);
            check($sformatf("v%0d busy", i), 32'(read_busy), 32'(tbl[i].e_busy));
            check($sformatf("v%0d ready", i), 32'(reserve_ready), 32'(tbl[i].e_rdy));
            check($sformatf("v%0d sb_error", i), 32'(sb_error), 32'(tbl[i].e_err));
        end

        // Reset clears the sticky error and storage; inputs during reset are ignored.
        drive(1, 0, 0, 1, 4, 32'h44, 1, 4);
        drive(0, 5, 4, 0, 0, 0, 0, 4);
        check("clr sb_error", 32'(sb_error), 32'h0);
        check("clr x5", read_data[0], 32'h0);
        check("clr x4", read_data[1], 32'h0);
        check("clr busy", 32'(read_busy), 32'h0);
        check("clr ready", 32'(reserve_ready), 32'h1);

        // Writeback of x9 while reading it.
        drive(0, 0, 0, 0, 0, 0, 1, 9);
        drive(0, 9, 9, 1, 9, 32'hA5A5A5A5, 0, 0);
`ifdef REGFILE_BYPASS_EN
        check("byp d0", read_data[0], 32'hA5A5A5A5);
        check("byp d1", read_data[1], 32'hA5A5A5A5);
        check("byp busy", 32'(read_busy), 32'h0);
`else
        check("byp d0", read_data[0], 32'h0);
        check("byp d1", read_data[1], 32'h0);
        check("byp busy", 32'(read_busy), 32'h3);
`endif
        drive(0, 9, 0, 0, 0, 0, 0, 0);
        check("x9 after d0", read_data[0], 32'hA5A5A5A5);
        check("x9 after busy", 32'(read_busy), 32'h0);
        check("x9 sb_error", 32'(sb_error), 32'h0);

        // Reset in the middle of x12 reservations, then an orphan writeback.
        drive(0, 0, 0, 0, 0, 0, 1, 12);
        drive(0, 12, 0, 0, 0, 0, 1, 12);
        check("x12 busy", 32'(read_busy), 32'h1);
        check("x12 ready", 32'(reserve_ready), 32'h1);
        drive(1, 12, 0, 0, 0, 0, 1, 12);
        drive(0, 12, 9, 1, 12, 32'h12, 0, 12);
        check("mid rst busy", 32'(read_busy), 32'h0);
        check("mid rst ready", 32'(reserve_ready), 32'h1);
        check("mid rst x9", read_data[1], 32'h0);
        check("mid rst sb_error", 32'(sb_error), 32'h0);
        drive(0, 12, 0, 0, 0, 0, 0, 0);
        check("orphan sb_error", 32'(sb_error), 32'h1);
        check("orphan x12", read_data[0], 32'h12);
        check("orphan busy", 32'(read_busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with N combinational read ports, one write port, and an integrated per-register pending-write scoreboard. It replaces the fixed 2-read/32×32 register file for the pipelined core. Decode reserves a destination at issue, writeback clears it, and read ports report whether their operand is still in flight so hazard logic can stall. Optional write-to-read bypass lets an operand be consumed in the same cycle it is written back.

## Interface
Parameters:
- XLEN, 32, register width in bits
- NREGS, 32, number of architectural registers (power of two, ≥ 2); AW = $clog2(NREGS)
- NRD, 2, number of read ports (≥ 1)
- MAX_PENDING, 3, maximum outstanding reservations per register (≥ 1); CW = $clog2(MAX_PENDING+1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- read_reg  in  NRD×AW  read addresses, packed [NRD-1:0][AW-1:0]
- read_data  out  NRD×XLEN  read data per port
- read_busy  out  NRD  operand at that port has pending reservation(s)
- write_reg  in  AW  writeback destination
- write_data  in  XLEN  writeback data
- regwrite  in  1  writeback enable
- reserve_valid  in  1  issue requests reservation of reserve_reg
- reserve_reg  in  AW  register to reserve
- reserve_ready  out  1  reservation of reserve_reg can be accepted this cycle
- sb_error  out  1  sticky: writeback arrived for a register with zero pending count

## Operation
- Storage: x[0..NREGS-1], XLEN each; x0 is hardwired to 0. Writes to x0 are ignored. x0 is never busy and is always reservable.
- Write: if regwrite && write_reg != 0, then x[write_reg] <= write_data at the clock edge.
- Read: read_data[i] = x[read_reg[i]], combinational; no X output for any address.
- Pending counter cnt[r] (CW bits) per register r ≠ 0:
  - reserve accepted (reserve_valid && reserve_ready) only: +1
  - regwrite to r only: −1, saturating at 0; if cnt[r] == 0, sb_error <= 1
  - both events in the same cycle on the same r: cnt unchanged; no error unless cnt == 0 (in that case cnt becomes 1 and the error is flagged)
- reserve_ready = (reserve_reg == 0) || (cnt[reserve_reg] != MAX_PENDING) || (regwrite && write_reg == reserve_reg). A simultaneous writeback frees a slot.
- reserve_valid && !reserve_ready: request dropped, no state change. Issue must hold and retry.
- read_busy[i] = cnt[read_reg[i]] != 0 (always 0 for x0), subject to the bypass rule under Configuration.
- sb_error is cleared only by reset.

## Timing
- Read data/busy: 0-cycle latency (combinational from addresses and current state). A write is visible on read_data the cycle after the edge that commits it (unless bypassed).
- Counter updates and busy changes are visible the cycle after the edge.
- Reset (any cycle, including mid-reservation): all x = 0, all cnt = 0, sb_error = 0. The next cycle shows read_data = 0, read_busy = 0, reserve_ready = 1. Inputs during the reset cycle are ignored.
- No multi-cycle state machine; each register's counter is an independent up/down counter with saturation at 0 and a hold at MAX_PENDING.

## Configuration
- REGFILE_BYPASS_EN defined:
  - If regwrite && write_reg != 0 && write_reg == read_reg[i], then read_data[i] = write_data.
  - read_busy[i] = 0 if that writeback takes cnt from 1 to 0 with no same-register reservation accepted in that cycle.
- REGFILE_BYPASS_EN undefined:
  - read_data[i] returns the pre-write value.
  - read_busy[i] reflects cnt before the edge.
  - The consumer waits one extra cycle.

## Structure
- Shared package regfile_pkg holds:
  - default XLEN/NREGS constants
  - typedef reg_addr_t (logic [AW-1:0])
  - typedef xword_t (logic [XLEN-1:0])
- Sub-module sb_counter: one pending counter with inc/dec inputs, MAX_PENDING parameter, full/nonzero/underflow outputs. It is instantiated NREGS−1 times via generate.
- Storage and read muxing stay in the top module.

## Test plan
- Reset, then read x0..x31 on all ports -> read_data = 0, read_busy = 0, reserve_ready = 1, sb_error = 0.
- Write x5 = 0xDEADBEEF, read x5 next cycle -> 0xDEADBEEF; write x0 = 0x1234 -> x0 reads 0.
- Reserve x7 3 times (MAX_PENDING = 3) -> reserve_ready = 0 for x7. A 4th reserve is dropped. A writeback of x7 in the same cycle as the 4th reserve -> accepted, cnt stays 3.
- Reserve x9 once; next cycle write x9 = 0xA5A5A5A5 while reading x9:
  - with REGFILE_BYPASS_EN -> data 0xA5A5A5A5, busy 0 that cycle
  - without -> old data, busy 1, then 0xA5A5A5A5 / busy 0 next cycle
- Writeback x3 with cnt[3] = 0 -> sb_error = 1 and it stays 1, cnt[3] remains 0. Reset -> sb_error = 0.
- Reserve x12 twice, assert reset mid-sequence -> next cycle read_busy for x12 = 0, reserve_ready = 1; the later writeback of x12 sets sb_error.
